// File: rtl/countdown_ctrl.sv
// countdown_ctrl: two-digit BCD countdown sequencer with run/pause/alarm
// control, one-second tick prescaler and buzzer enable.
module countdown_ctrl #(
    parameter int unsigned TICK_DIV       = 25000000,
    parameter int unsigned ALARM_SECS     = 5,
    parameter logic [7:0]  PRESET_DEFAULT = 8'h99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       load,
    input  logic [7:0] preset,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic       alarm,
    output logic [1:0] state
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [3:0]    ALARM_LAST = 4'(ALARM_SECS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        ALARM = 2'd3
    } state_t;

    state_t        st;
    logic [PW-1:0] presc;
    logic [3:0]    alarm_cnt;
    logic [7:0]    preset_q;
    logic          start_hist;
    logic          stop_hist;
    logic          start_press;
    logic          stop_press;
    logic          armed;

    logic          tick;
    logic          go_start;
    logic [7:0]    san;
    logic [7:0]    dec;

    function automatic logic [3:0] clamp9(input logic [3:0] n);
        return (n > 4'd9) ? 4'd9 : n;
    endfunction

    assign state = st;

    // Tick detect, sanitised preset, BCD decrement and press arbitration
    always_comb begin
        tick     = 1'b0;
        go_start = 1'b0;
        san      = {clamp9(preset[7:4]), clamp9(preset[3:0])};
        dec      = {d1, d0};
        if ((st == RUN || st == ALARM) && presc == PRESC_LAST) begin
            tick = 1'b1;
        end
        if (d0 == 4'd0) begin
            dec = {d1 - 4'd1, 4'd9};
        end else begin
            dec = {d1, d0 - 4'd1};
        end
        // stop wins over a simultaneous start
        go_start = start_press & ~stop_press;
    end

    // Button edge pipeline, prescaler, count and state machine
    always_ff @(posedge clk) begin
        if (!rst) begin
            st          <= IDLE;
            {d1, d0}    <= PRESET_DEFAULT;
            preset_q    <= PRESET_DEFAULT;
            alarm       <= 1'b0;
            presc       <= '0;
            alarm_cnt   <= '0;
            start_hist  <= 1'b0;
            stop_hist   <= 1'b0;
            start_press <= 1'b0;
            stop_press  <= 1'b0;
            armed       <= 1'b0;
        end else begin
            // armed masks the first cycle so a held button cannot fake an edge
            start_hist  <= btn_start;
            stop_hist   <= btn_stop;
            armed       <= 1'b1;
            start_press <= armed & btn_start & ~start_hist;
            stop_press  <= armed & btn_stop & ~stop_hist;

            case (st)
                IDLE: begin
                    presc     <= '0;
                    alarm_cnt <= '0;
                    alarm     <= 1'b0;
                    if (load) begin
                        {d1, d0} <= san;
                        preset_q <= san;
                    end
                    if (go_start && (load ? (san != 8'h00) : ({d1, d0} != 8'h00))) begin
                        st <= RUN;
                    end
                end

                RUN: begin
                    presc <= tick ? '0 : presc + 1'b1;
                    if (stop_press) begin
                        st <= PAUSE;
                    end else if (tick) begin
                        {d1, d0} <= dec;
                        if (dec == 8'h00) begin
                            st    <= ALARM;
                            alarm <= 1'b1;
                            presc <= '0;
                        end
                    end
                end

                PAUSE: begin
                    if (stop_press) begin
                        st <= IDLE;
                    end else if (start_press) begin
                        st <= RUN;
                    end
                end

                ALARM: begin
                    presc <= tick ? '0 : presc + 1'b1;
                    if (stop_press || (tick && alarm_cnt == ALARM_LAST)) begin
                        st        <= IDLE;
                        alarm     <= 1'b0;
                        {d1, d0}  <= preset_q;
                        alarm_cnt <= '0;
                        presc     <= '0;
                    end else if (tick) begin
                        alarm_cnt <= alarm_cnt + 4'd1;
                    end
                end

                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
Sequencing controller for the two-digit BCD countdown timer subsystem. Owns the BCD count, the run/pause/alarm state machine, the one-second tick prescaler and the alarm enable for the buzzer. It replaces the free-running down-counter. Its digit outputs feed the 2-digit seven-segment scanner; its alarm output gates the buzzer tone generator.

Parameters:
TICK_DIV, 25000000, clk cycles per count tick (1 s at 25 MHz); minimum 2.
ALARM_SECS, 5, ticks the alarm stays on before auto-return to IDLE; 1..15.
PRESET_DEFAULT, 8'h99, BCD count and latched preset after reset.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low
btn_start  input  1  debounced start/resume level, synchronous to clk
btn_stop  input  1  debounced pause/stop/silence level, synchronous to clk
load  input  1  level; loads preset while IDLE
preset  input  8  BCD preset {tens, units}
d1  output  4  BCD tens digit of count
d0  output  4  BCD units digit of count
alarm  output  1  buzzer enable, high only in ALARM
state  output  2  0=IDLE, 1=RUN, 2=PAUSE, 3=ALARM

Behaviour:
- Reset (rst low at posedge): state=IDLE, {d1,d0}=PRESET_DEFAULT, latched preset=PRESET_DEFAULT, alarm=0, prescaler=0, alarm counter=0, button history regs=0. No start/stop edge is detected on the first cycle after reset release.
- Button press = rising edge: level high this cycle, low in the registered previous sample. Press acts one cycle after the edge is sampled. Holding a button gives one press.
- Start and stop pressed in the same cycle: stop wins, start is discarded.
- Preset sanitising: any nibble >9 is clamped to 9 when loaded.
- Prescaler: counts 0..TICK_DIV-1 only in RUN and ALARM. tick=1 in the cycle the prescaler equals TICK_DIV-1; the prescaler then wraps to 0. The prescaler holds in PAUSE and clears to 0 in IDLE and on entry to ALARM.
- IDLE:
  - load=1: {d1,d0} and latched preset take the sanitised preset on the next edge.
  - Start press with count != 00: go to RUN. If load and start are in the same cycle, load applies and start is evaluated against the new value.
  - Start press with count == 00: ignored.
  - Stop press: no effect.
- RUN:
  - On tick: BCD decrement. If d0==0 then d0=9 and d1=d1-1, else d0=d0-1.
  - If the decremented value is 00, go to ALARM in the same edge. The count shows 00.
  - Stop press: go to PAUSE. A stop press coinciding with a tick suppresses that decrement.
  - Start press and load: ignored.
- PAUSE:
  - Count and prescaler frozen.
  - Start press: go to RUN, resuming the partial second.
  - Stop press: go to IDLE, count unchanged.
  - load: ignored.
- ALARM:
  - alarm=1, registered, asserted the cycle state becomes ALARM. Count held at 00.
  - Alarm counter increments on each tick.
  - When it reaches ALARM_SECS, or on a stop press: go to IDLE, alarm=0, {d1,d0}=latched preset, alarm counter cleared.
  - Start press and load: ignored.
- All outputs are registered. d1/d0 never leave 0..9. There is no wrap below 00.
- rst low in any state has the reset effect on that edge, overriding every other input.

Test Plan:
- Reset/load (TICK_DIV=4):
  - rst low 2 cycles, then high → d1:d0=9:9, state=0, alarm=0.
  - load with preset=8'h3C → d1:d0=3:9.
- Countdown and borrow: preset 8'h11, start press → state=1. Count reads 10 after 4 cycles, 09 after 8, 00 after 44. At that edge state=3 and alarm=1.
- Alarm timeout (ALARM_SECS=2): after reaching 00, alarm stays 1 for 8 cycles, then state=0, alarm=0, d1:d0=1:1 (preset restored). A stop press inside ALARM silences immediately with the same reload.
- Pause/resume:
  - Stop press 2 cycles into a second → state=2, count frozen for 20 cycles.
  - Start press → next decrement after 2 more cycles, not 4.
  - A second stop press while in PAUSE → state=0, count kept.
- Simultaneous/ignored events:
  - Start+stop in the same cycle in RUN → PAUSE.
  - Stop press on the tick cycle → no decrement.
  - Start in IDLE with count 00 → stays IDLE.
  - load during RUN → count unaffected.
  - Holding btn_start high 10 cycles → only one press.
- Reset mid-operation: rst low during RUN at count 45 → next edge d1:d0=9:9, state=0, alarm=0. A start level still high after release does not start the timer.
